// File: rtl/cxl_speckv_pkg.sv
// Shared definitions for the KV prefetch DMA: descriptor field layout and FSM states.
package cxl_speckv_pkg;

    localparam int SRC_ADDR_LSB      = 0;
    localparam int SRC_ADDR_W        = 64;
    localparam int BYTES_LSB         = 64;
    localparam int BYTES_W           = 32;
    localparam int FLAGS_LSB         = 96;
    localparam int FLAGS_W           = 8;
    localparam int FLAG_PREFETCH_BIT = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_REPORT = 3'd4
    } dma_state_e;

endpackage

// File: rtl/kv_desc_fifo.sv
// Descriptor FIFO with array storage and a registered head read.
// DEPTH must be a power of two, at least 2.
module kv_desc_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    // A full FIFO may still take a push in the cycle it pops (pop-then-push).
    assign do_push   = push && (!full || do_pop);
    assign head_data = head_reg;

    // Head is valid one cycle after the head slot is written or the read pointer moves;
    // the consumer never pops two cycles in a row, so this latency is always hidden.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
        head_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/kv_prefetch_dma.sv
// KV prefetch DMA: queues descriptors and splits each into boundary-aligned read bursts.
// Optional statistics counters are built when PREFETCH_DMA_STATS_EN is defined.
module kv_prefetch_dma
    import cxl_speckv_pkg::*;
#(
    parameter int DESC_WIDTH      = 128,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_BURST_BYTES = 256,
    parameter int MAX_OUTSTANDING = 8,
    localparam int TAG_W          = $clog2(MAX_OUTSTANDING)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [DESC_WIDTH-1:0] desc_data,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    output logic [63:0]           rd_req_addr,
    output logic [15:0]           rd_req_len,
    output logic [TAG_W-1:0]      rd_req_tag,
    input  logic                  rd_cpl_valid,
    input  logic [TAG_W-1:0]      rd_cpl_tag,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [63:0]           done_addr,
    output logic                  busy,
`ifdef PREFETCH_DMA_STATS_EN
    output logic [31:0]           stat_desc_cnt,
    output logic [31:0]           stat_burst_cnt,
    output logic [31:0]           stat_stall_cnt,
`endif
    output logic                  err_spurious
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int OFF_W = $clog2(MAX_BURST_BYTES);

    dma_state_e state_reg;
    dma_state_e state_next;

    logic [63:0]           cur_addr_reg;
    logic [31:0]           remaining_reg;
    logic [63:0]           src_addr_reg;
    logic [OUT_W-1:0]      outstanding_reg;
    logic [TAG_W-1:0]      tag_reg;
    logic                  err_spurious_reg;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_pop;
    logic                  desc_push;
    logic [DESC_WIDTH-1:0] fifo_rd_data;
    logic [63:0]           load_addr;
    logic [31:0]           load_bytes;
    logic [31:0]           room;
    logic                  last_burst;
    logic                  req_hs;
    logic                  cpl_count;
    logic                  spurious;
    logic                  desc_unused;

    assign desc_push = desc_valid && desc_ready;

    kv_desc_fifo #(
        .WIDTH (DESC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (desc_push),
        .push_data (desc_data),
        .pop       (fifo_pop),
        .head_data (fifo_rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign load_addr   = fifo_rd_data[SRC_ADDR_LSB +: SRC_ADDR_W];
    assign load_bytes  = fifo_rd_data[BYTES_LSB +: BYTES_W];
    // Flags (including the prefetch hint) and reserved bits carry no behaviour here.
    assign desc_unused = ^{fifo_rd_data[DESC_WIDTH-1:FLAGS_LSB],
                           fifo_rd_data[FLAGS_LSB + FLAG_PREFETCH_BIT], rd_cpl_tag};

    // Bytes left before the next MAX_BURST_BYTES-aligned boundary.
    assign room        = 32'(MAX_BURST_BYTES) - 32'(cur_addr_reg[OFF_W-1:0]);
    assign last_burst  = (remaining_reg <= room);
    assign rd_req_addr = cur_addr_reg;
    assign rd_req_len  = 16'((remaining_reg < room) ? remaining_reg : room);
    assign rd_req_tag  = tag_reg;

    assign req_hs      = rd_req_valid && rd_req_ready;
    assign cpl_count   = rd_cpl_valid && ((outstanding_reg != '0) || req_hs);
    assign spurious    = rd_cpl_valid && (outstanding_reg == '0) && !req_hs;

    assign desc_ready   = !fifo_full;
    assign busy         = !fifo_empty || (state_reg != ST_IDLE);
    assign done_addr    = src_addr_reg;
    assign err_spurious = err_spurious_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        fifo_pop     = 1'b0;
        rd_req_valid = 1'b0;
        done_valid   = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                fifo_pop   = 1'b1;
                state_next = (load_bytes == '0) ? ST_IDLE : ST_ISSUE;
            end
            ST_ISSUE: begin
                rd_req_valid = (outstanding_reg < OUT_W'(MAX_OUTSTANDING));
                if (rd_req_valid && rd_req_ready && last_burst) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (outstanding_reg == '0) begin
                    state_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_addr_reg     <= '0;
            remaining_reg    <= '0;
            src_addr_reg     <= '0;
            outstanding_reg  <= '0;
            tag_reg          <= '0;
            err_spurious_reg <= 1'b0;
        end else begin
            if (fifo_pop && (load_bytes != '0)) begin
                cur_addr_reg  <= load_addr;
                remaining_reg <= load_bytes;
                src_addr_reg  <= load_addr;
            end else if (req_hs) begin
                cur_addr_reg  <= cur_addr_reg + 64'(rd_req_len);
                remaining_reg <= remaining_reg - 32'(rd_req_len);
            end
            if (req_hs) begin
                tag_reg <= (tag_reg == TAG_W'(MAX_OUTSTANDING - 1)) ? '0 : tag_reg + TAG_W'(1);
            end
            case ({req_hs, cpl_count})
                2'b10:   outstanding_reg <= outstanding_reg + OUT_W'(1);
                2'b01:   outstanding_reg <= outstanding_reg - OUT_W'(1);
                default: ;
            endcase
            if (spurious) begin
                err_spurious_reg <= 1'b1;
            end
        end
    end

`ifdef PREFETCH_DMA_STATS_EN
    logic [2:0] stat_inc;

    assign stat_inc[0] = fifo_pop && (load_bytes != '0);
    assign stat_inc[1] = req_hs;
    assign stat_inc[2] = (state_reg == ST_ISSUE) && !req_hs;

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        logic [31:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (stat_inc[gi] && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + 32'd1;
            end
        end
    end

    assign stat_desc_cnt  = g_stat[0].cnt_reg;
    assign stat_burst_cnt = g_stat[1].cnt_reg;
    assign stat_stall_cnt = g_stat[2].cnt_reg;
`endif

endmodule
